mips_imem_loader: RTL and testbench

MIPS_IMEM_LOADER -- requirements
Module: mips_imem_loader

---
 rtl/mips_ldr_pkg.sv | 18 +
 rtl/mips_ser_shift.sv | 43 ++++
 rtl/mips_imem_loader.sv | 151 +++++++++++++++
 tb/tb_mips_imem_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ldr_pkg.sv
// Shared definitions for the MIPS instruction-memory serial loader.
//   WORD_W_DEF : default instruction word width
//   ADDR_W_DEF : default instruction-memory address width
//   ldr_state_e: loader FSM states
package mips_ldr_pkg;

  localparam int unsigned WORD_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } ldr_state_e;

endpackage

// File: rtl/mips_ser_shift.sv
// MSB-first serial-to-parallel shifter with bit counter.
//   clk, reset   : clock, async active-high reset
//   clear        : synchronous clear of shift register and bit counter
//   shift_en     : shift ser_in in this cycle
//   ser_in       : serial data bit
//   word_c       : word as it would read with the current bit appended
//   word_rdy_c   : current bit completes a word (word_c is valid)
module mips_ser_shift #(
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              ser_in,
  output logic [WORD_W-1:0] word_c,
  output logic              word_rdy_c
);

  localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  // Only WORD_W-1 bits are stored; the last bit is used live from ser_in.
  logic [WORD_W-2:0] sreg_q;
  logic [CNT_W-1:0]  cnt_q;

  assign word_c     = {sreg_q, ser_in};
  assign word_rdy_c = shift_en && (cnt_q == CNT_W'(WORD_W - 1));

  // Shift register and bit counter; counter wraps at the word boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (shift_en) begin
      sreg_q <= word_c[WORD_W-2:0];
      cnt_q  <= word_rdy_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_imem_loader.sv
// Serial program loader for the mips_16 instruction memory.
// A rising edge on ld_en starts a load: a WORD_W header holding the word
// count N, then N words written to addresses 0..N-1. The core is held in
// reset until a load completes.
//   clk, reset  : clock, async active-high reset
//   ld_en       : load enable, must stay high for the whole load
//   ser_valid   : strobe qualifying ser_in
//   ser_in      : serial data, MSB first
//   imem_we     : one-cycle instruction-memory write strobe
//   imem_addr   : write address (holds last value)
//   imem_wdata  : write data (holds last value)
//   core_reset  : core reset, low only when a program is loaded
//   load_done   : load completed
//   load_err    : load aborted or header out of range
module mips_imem_loader
  import mips_ldr_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic              ser_valid,
  input  logic              ser_in,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err
);

  // One extra bit so a full-depth count (2**ADDR_W) is representable.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CMP_W = (WORD_W > CNT_W) ? WORD_W : CNT_W;

  ldr_state_e        state_q, state_d;
  logic              ld_en_q;
  logic [CNT_W-1:0]  idx_q, idx_d, n_q, n_d, idx_inc_c;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [WORD_W-1:0] wdata_d;

  logic              rise_c, loading_c, start_c, abort_c;
  logic              shift_en_c, shift_clr_c, word_rdy_c;
  logic [WORD_W-1:0] word_c;

  assign rise_c      = ld_en & ~ld_en_q;
  assign loading_c   = (state_q == HDR) || (state_q == DATA);
  assign start_c     = rise_c & ~loading_c;
  assign abort_c     = ~ld_en & loading_c;
  // Bits are taken only while loading with ld_en still high; the rise cycle itself is in IDLE/DONE/ERR and so ignored.
  assign shift_en_c  = ser_valid & ld_en & loading_c;
  assign shift_clr_c = start_c | abort_c;
  assign idx_inc_c   = idx_q + CNT_W'(1);

  mips_ser_shift #(
    .WORD_W (WORD_W)
  ) u_shift (
    .clk        (clk),
    .reset      (reset),
    .clear      (shift_clr_c),
    .shift_en   (shift_en_c),
    .ser_in     (ser_in),
    .word_c     (word_c),
    .word_rdy_c (word_rdy_c)
  );

  // Next-state, counters and next output values.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    we_d    = 1'b0;
    addr_d  = imem_addr;
    wdata_d = imem_wdata;
    case (state_q)
      HDR: begin
        if (abort_c) begin
          state_d = ERR;
        end else if (word_rdy_c) begin
          if (word_c == '0) begin
            state_d = DONE;
          end else if (CMP_W'(word_c) > CMP_W'(DEPTH)) begin
            state_d = ERR;
          end else begin
            n_d     = CNT_W'(word_c);
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (abort_c) begin
          state_d = ERR;
        end else if (word_rdy_c) begin
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_W-1:0];
          wdata_d = word_c;
          idx_d   = idx_inc_c;
          if (idx_inc_c == n_q) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        if (start_c) begin
          state_d = HDR;
          idx_d   = '0;
          n_d     = '0;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, edge detector and registered outputs (status follows next state).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_en_q    <= 1'b0;
      idx_q      <= '0;
      n_q        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      ld_en_q    <= ld_en;
      idx_q      <= idx_d;
      n_q        <= n_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      core_reset <= (state_d != DONE);
      load_done  <= (state_d == DONE);
      load_err   <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_mips_imem_loader.sv
// Self-checking bench for mips_imem_loader: table of load scenarios with a
// write scoreboard, plus hand-written reset sequences.
module tb_mips_imem_loader;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_en;
  logic              ser_valid;
  logic              ser_in;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic              core_reset;
  logic              load_done;
  logic              load_err;

  always #5 clk = ~clk;

  mips_imem_loader #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_en      (ld_en),
    .ser_valid  (ser_valid),
    .ser_in     (ser_in),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  typedef struct {
    logic [15:0] hdr;
    int          nsend;     // full data words sent
    int          extra;     // trailing partial-word bits
    bit          drop;      // drop ld_en after the bits
    bit          gaps;      // idle cycles between valid bits
    int          mode;      // 0 fixed list, 1 value=addr, 2 random
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks  = 0;
  int  errors  = 0;
  int  wr_seen = 0;

  logic [15:0] fixed_words [3] = '{16'h1234, 16'hABCD, 16'h0F0F};
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected at %0t",
                 imem_addr, imem_wdata, $time);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(w.addr));
        chk("wr_data", 32'(imem_wdata), 32'(w.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    ser_valid = 1'b1;
    ser_in    = b;
    tick();
    ser_valid = 1'b0;
    ser_in    = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send_word(input logic [15:0] w, input int nbits, input bit gaps);
    for (int i = 15; i > 15 - nbits; i--) send_bit(w[i], gaps);
  endtask

  task automatic check_status(input string tag, input bit done, input bit err);
    chk({tag, "_load_done"},  32'(load_done),  32'(done));
    chk({tag, "_load_err"},   32'(load_err),   32'(err));
    chk({tag, "_core_reset"}, 32'(core_reset), 32'(!done));
  endtask

  task automatic run_load(input int id, input vec_t v);
    logic [15:0] data;
    int          nexp;
    bit          hdr_ok;
    wr_t         last;
    nexp    = 0;
    wr_seen = 0;
    last    = '0;
    hdr_ok  = (v.hdr != 16'h0) && (v.hdr <= 16'h0100);
    // Rising edge with a junk valid bit that must be ignored.
    ld_en     = 1'b1;
    ser_valid = 1'b1;
    ser_in    = 1'b1;
    tick();
    ser_valid = 1'b0;
    ser_in    = 1'b0;
    send_word(v.hdr, 16, v.gaps);
    if (hdr_ok) begin
      @(negedge clk);
      chk($sformatf("v%0d_core_reset_loading", id), 32'(core_reset), 32'd1);
      chk($sformatf("v%0d_done_loading", id), 32'(load_done), 32'd0);
    end
    for (int w = 0; w < v.nsend; w++) begin
      case (v.mode)
        0:       data = fixed_words[w];
        1:       data = 16'(w);
        default: data = 16'($urandom);
      endcase
      if (hdr_ok && (w < int'(v.hdr))) begin
        last = '{addr: 8'(w), data: data};
        exp_q.push_back(last);
        nexp++;
      end
      send_word(data, 16, v.gaps);
    end
    if (v.extra > 0) send_word(16'($urandom), v.extra, v.gaps);
    if (v.drop) ld_en = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_status($sformatf("v%0d", id), v.exp_done, v.exp_err);
    chk($sformatf("v%0d_we_idle", id), 32'(imem_we), 32'd0);
    chk($sformatf("v%0d_write_count", id), 32'(wr_seen), 32'(nexp));
    chk($sformatf("v%0d_writes_outstanding", id), 32'(exp_q.size()), 32'd0);
    if (nexp > 0) begin
      chk($sformatf("v%0d_addr_hold", id), 32'(imem_addr), 32'(last.addr));
      chk($sformatf("v%0d_data_hold", id), 32'(imem_wdata), 32'(last.data));
    end
    exp_q.delete();
    ld_en = 1'b0;
    tick();
    @(negedge clk);
    check_status($sformatf("v%0d_after_ld_en_low", id), v.exp_done, v.exp_err);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_imem_we"},    32'(imem_we),    32'd0);
    chk({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    chk({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
    check_status(tag, 1'b0, 1'b0);
  endtask

  initial begin
    //            hdr       nsend extra drop gaps mode done err
    vecs[0] = '{16'h0003,   3,    0,    0,   0,   0,   1,   0};
    vecs[1] = '{16'h0000,   0,    0,    0,   0,   2,   1,   0};
    vecs[2] = '{16'h0101,   0,    0,    0,   0,   2,   0,   1};
    vecs[3] = '{16'h0005,   2,    7,    1,   0,   2,   0,   1};
    vecs[4] = '{16'h0100,   256,  0,    0,   0,   1,   1,   0};
    vecs[5] = '{16'h0002,   2,    0,    0,   1,   2,   1,   0};
    vecs[6] = '{16'hFFFF,   1,    0,    0,   0,   2,   0,   1};
    vecs[7] = '{16'h0001,   1,    0,    0,   0,   2,   1,   0};

    reset     = 1'b1;
    ld_en     = 1'b0;
    ser_valid = 1'b0;
    ser_in    = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check_reset_values("idle");

    foreach (vecs[i]) run_load(i, vecs[i]);

    // Reset asserted mid-DATA with gapped bits.
    begin
      logic [15:0] d0;
      int          seen;
      d0      = 16'h5A3C;
      wr_seen = 0;
      ld_en   = 1'b1;
      tick();
      send_word(16'h0004, 16, 1'b1);
      exp_q.push_back('{addr: 8'h00, data: d0});
      send_word(d0, 16, 1'b1);
      send_word(16'hFFFF, 9, 1'b1);
      #2 reset = 1'b1;
      #1;
      check_reset_values("mid_data_reset");
      chk("mid_data_first_write", 32'(wr_seen), 32'd1);
      exp_q.delete();
      seen = wr_seen;
      for (int i = 0; i < 4; i++) send_bit(1'(i), 1'b0);
      ld_en = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0);
      @(negedge clk);
      chk("post_reset_no_writes", 32'(wr_seen), 32'(seen));
      check_reset_values("post_reset_idle");
    end

    // ld_en already high when reset deasserts counts as a rising edge.
    begin
      reset   = 1'b1;
      ld_en   = 1'b1;
      wr_seen = 0;
      tick();
      reset     = 1'b0;
      ser_valid = 1'b1;
      ser_in    = 1'b1;
      tick();
      ser_valid = 1'b0;
      ser_in    = 1'b0;
      send_word(16'h0001, 16, 1'b0);
      exp_q.push_back('{addr: 8'h00, data: 16'hC0DE});
      send_word(16'hC0DE, 16, 1'b0);
      repeat (2) tick();
      @(negedge clk);
      check_status("ld_en_high_at_reset", 1'b1, 1'b0);
      chk("ld_en_high_at_reset_writes", 32'(wr_seen), 32'd1);
      chk("ld_en_high_at_reset_outstanding", 32'(exp_q.size()), 32'd0);
      ld_en = 1'b0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
